// File: rtl/clk_div_pkg.sv
// Shared constants, counter type and period clamp for the programmable clock divider.
package clk_div_pkg;

    localparam int CNT_W_DEF   = 28;
    localparam int DIV_DEFAULT = 50_000_000;
    localparam int HI_DEFAULT  = 25_000_000;
    localparam int MIN_DIV     = 2;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    // A period below two cycles cannot produce both a high and a low phase.
    function automatic cnt_t clamp_div(input cnt_t div);
        return (div < cnt_t'(MIN_DIV)) ? cnt_t'(MIN_DIV) : div;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable divider; sync exists only with CLK_DIV_PHASE_ALIGN_EN.
interface clk_div_prog_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 28
);
    logic [N_CH-1:0]       en;
    logic [N_CH-1:0]       load;
    logic [N_CH*CNT_W-1:0] div_val;
    logic [N_CH*CNT_W-1:0] hi_val;
    logic [N_CH-1:0]       load_ack;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick;
`ifdef CLK_DIV_PHASE_ALIGN_EN
    logic                  sync;

    modport master (output en, load, div_val, hi_val, sync,
                    input  load_ack, clk_out, tick);
    modport slave  (input  en, load, div_val, hi_val, sync,
                    output load_ack, clk_out, tick);
`else
    modport master (output en, load, div_val, hi_val,
                    input  load_ack, clk_out, tick);
    modport slave  (input  en, load, div_val, hi_val,
                    output load_ack, clk_out, tick);
`endif
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow/active period and high time, registered outputs.
// With CLK_DIV_PHASE_ALIGN_EN defined, a sync input forces a wrap on an enabled channel.
module clk_div_chan #(
    parameter int CNT_W       = clk_div_pkg::CNT_W_DEF,
    parameter int DIV_DEFAULT = clk_div_pkg::DIV_DEFAULT,
    parameter int HI_DEFAULT  = clk_div_pkg::HI_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
`ifdef CLK_DIV_PHASE_ALIGN_EN
    input  logic             sync,
`endif
    input  logic [CNT_W-1:0] div_in,
    input  logic [CNT_W-1:0] hi_in,
    output logic             load_ack,
    output logic             clk_out,
    output logic             tick
);
    import clk_div_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] p_act_reg, h_act_reg, p_sh_reg, h_sh_reg, cnt_reg;
    logic             pending_reg, clk_out_reg, tick_reg, load_ack_reg;
    logic [CNT_W-1:0] p_new, h_new, cnt_inc, div_clamped;
    logic             wrap, apply;

    assign p_new       = pending_reg ? p_sh_reg : p_act_reg;
    assign h_new       = pending_reg ? h_sh_reg : h_act_reg;
    assign cnt_inc     = cnt_reg + CNT_ONE;
    assign div_clamped = CNT_W'(clamp_div(cnt_t'(div_in)));

`ifdef CLK_DIV_PHASE_ALIGN_EN
    assign wrap = en && (sync || (cnt_reg == p_act_reg - CNT_ONE));
`else
    assign wrap = en && (cnt_reg == p_act_reg - CNT_ONE);
`endif
    // New settings only land on a period boundary (or while idle), so no period is cut short.
    assign apply = pending_reg && (wrap || !en);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            p_act_reg    <= CNT_W'(DIV_DEFAULT);
            h_act_reg    <= CNT_W'(HI_DEFAULT);
            p_sh_reg     <= CNT_W'(DIV_DEFAULT);
            h_sh_reg     <= CNT_W'(HI_DEFAULT);
            cnt_reg      <= CNT_W'(DIV_DEFAULT - 1);
            pending_reg  <= 1'b0;
            clk_out_reg  <= 1'b0;
            tick_reg     <= 1'b0;
            load_ack_reg <= 1'b0;
        end else begin
            load_ack_reg <= apply;
            if (apply) begin
                p_act_reg <= p_sh_reg;
                h_act_reg <= h_sh_reg;
            end
            if (load) begin
                p_sh_reg <= div_clamped;
                h_sh_reg <= hi_in;
            end
            pending_reg <= load || (pending_reg && !apply);

            // Parking at P-1 while idle makes the first enabled edge a wrap.
            if (!en) begin
                cnt_reg     <= p_new - CNT_ONE;
                clk_out_reg <= 1'b0;
                tick_reg    <= 1'b0;
            end else if (wrap) begin
                cnt_reg     <= '0;
                tick_reg    <= 1'b1;
                clk_out_reg <= (h_new != '0);
            end else begin
                cnt_reg     <= cnt_inc;
                tick_reg    <= 1'b0;
                clk_out_reg <= (cnt_inc < h_act_reg);
            end
        end
    end

    assign load_ack = load_ack_reg;
    assign clk_out  = clk_out_reg;
    assign tick     = tick_reg;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock/tick generator: one clk_div_chan per channel on a sliced bus.
// CLK_DIV_PHASE_ALIGN_EN adds a shared sync input that phase-aligns all enabled channels.
module clk_div_prog #(
    parameter int N_CH        = 2,
    parameter int CNT_W       = clk_div_pkg::CNT_W_DEF,
    parameter int DIV_DEFAULT = clk_div_pkg::DIV_DEFAULT,
    parameter int HI_DEFAULT  = clk_div_pkg::HI_DEFAULT
) (
    input  logic          clk_in,
    input  logic          rst_n,
    clk_div_prog_if.slave bus
);
    logic [N_CH-1:0] load_ack_vec, clk_out_vec, tick_vec;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT),
            .HI_DEFAULT  (HI_DEFAULT)
        ) u_chan (
            .clk_in   (clk_in),
            .rst_n    (rst_n),
            .en       (bus.en[gi]),
            .load     (bus.load[gi]),
`ifdef CLK_DIV_PHASE_ALIGN_EN
            .sync     (bus.sync),
`endif
            .div_in   (bus.div_val[gi*CNT_W +: CNT_W]),
            .hi_in    (bus.hi_val[gi*CNT_W +: CNT_W]),
            .load_ack (load_ack_vec[gi]),
            .clk_out  (clk_out_vec[gi]),
            .tick     (tick_vec[gi])
        );
    end

    assign bus.load_ack = load_ack_vec;
    assign bus.clk_out  = clk_out_vec;
    assign bus.tick     = tick_vec;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed waveform patterns plus random traffic against a phase-based model.
// Exercises the sync input as well when CLK_DIV_PHASE_ALIGN_EN is defined.
module tb_clk_div_prog;
    localparam int N_CH  = 2;
    localparam int CNT_W = 28;
    localparam int DIV_D = 10;
    localparam int HI_D  = 5;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    bit   sync_v = 1'b0;

    always #5 clk_in = ~clk_in;

    clk_div_prog_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();
`ifdef CLK_DIV_PHASE_ALIGN_EN
    assign bus.sync = sync_v;
`endif

    clk_div_prog #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_D),
        .HI_DEFAULT  (HI_D)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: each channel is "idle" or "running at phase k of the active period".
    int m_p[N_CH], m_h[N_CH], m_psh[N_CH], m_hsh[N_CH], m_phase[N_CH];
    bit m_pend[N_CH], m_run[N_CH];
    logic [N_CH-1:0] exp_clk, exp_tick, exp_ack;
    logic [31:0] hist_clk[N_CH], hist_tick[N_CH], hist_ack[N_CH];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++) begin
            m_p[ch] = DIV_D;  m_h[ch] = HI_D;
            m_psh[ch] = DIV_D; m_hsh[ch] = HI_D;
            m_pend[ch] = 1'b0; m_run[ch] = 1'b0; m_phase[ch] = 0;
        end
        exp_clk = '0; exp_tick = '0; exp_ack = '0;
    endtask

    task automatic model_edge();
        for (int ch = 0; ch < N_CH; ch++) begin
            bit en_c, wrap_c, applied;
            en_c    = bus.en[ch];
            wrap_c  = en_c && (!m_run[ch] || (m_phase[ch] == m_p[ch] - 1) || sync_v);
            applied = m_pend[ch] && (wrap_c || !en_c);
            if (applied) begin
                m_p[ch] = m_psh[ch];
                m_h[ch] = m_hsh[ch];
                m_pend[ch] = 1'b0;
            end
            if (bus.load[ch]) begin
                int p_req;
                p_req = int'(bus.div_val[ch*CNT_W +: CNT_W]);
                m_psh[ch]  = (p_req < 2) ? 2 : p_req;
                m_hsh[ch]  = int'(bus.hi_val[ch*CNT_W +: CNT_W]);
                m_pend[ch] = 1'b1;
            end
            if (!en_c) m_run[ch] = 1'b0;
            else if (wrap_c) begin
                m_run[ch] = 1'b1;
                m_phase[ch] = 0;
            end else m_phase[ch]++;
            exp_ack[ch]  = applied;
            exp_tick[ch] = m_run[ch] && (m_phase[ch] == 0);
            exp_clk[ch]  = m_run[ch] && (m_phase[ch] < m_h[ch]);
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        check_eq("clk_out", 32'(bus.clk_out), 32'(exp_clk));
        check_eq("tick", 32'(bus.tick), 32'(exp_tick));
        check_eq("load_ack", 32'(bus.load_ack), 32'(exp_ack));
        for (int ch = 0; ch < N_CH; ch++) begin
            hist_clk[ch]  = {hist_clk[ch][30:0], bus.clk_out[ch]};
            hist_tick[ch] = {hist_tick[ch][30:0], bus.tick[ch]};
            hist_ack[ch]  = {hist_ack[ch][30:0], bus.load_ack[ch]};
        end
        bus.load = '0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic clr_hist();
        for (int ch = 0; ch < N_CH; ch++) begin
            hist_clk[ch] = '0; hist_tick[ch] = '0; hist_ack[ch] = '0;
        end
    endtask

    task automatic load_ch(input int ch, input int p, input int h);
        bus.load[ch] = 1'b1;
        bus.div_val[ch*CNT_W +: CNT_W] = CNT_W'(p);
        bus.hi_val[ch*CNT_W +: CNT_W]  = CNT_W'(h);
        $display("load ch%0d P=%0d H=%0d t=%0t", ch, p, h, $time);
    endtask

    // Idle the channel, load, and let the load apply while idle.
    task automatic reprogram(input int ch, input int p, input int h);
        bus.en[ch] = 1'b0;
        load_ch(ch, p, h);
        cycles(2);
    endtask

    initial begin
        bus.en = '0; bus.load = '0; bus.div_val = '0; bus.hi_val = '0;
        model_reset();
        clr_hist();
        #1;
        check_eq("reset_clk", 32'(bus.clk_out), 32'h0);
        check_eq("reset_tick", 32'(bus.tick), 32'h0);
        check_eq("reset_ack", 32'(bus.load_ack), 32'h0);
        #11 rst_n = 1'b1;
        cycles(2);

        // Even ratio on ch0, P=3 H=1 on ch1 concurrently
        load_ch(0, 4, 2);
        load_ch(1, 3, 1);
        cycle();
        cycle();
        check_eq("ack_after_load", 32'(bus.load_ack), 32'h3);
        clr_hist();
        bus.en = 2'b11;
        cycles(12);
        check_eq("even_clk", hist_clk[0] & 32'hFFF, 32'hCCC);
        check_eq("even_tick", hist_tick[0] & 32'hFFF, 32'h888);
        check_eq("ch1_p3_clk", hist_clk[1] & 32'hFFF, 32'h924);

        // Odd ratio/duty on ch0 while ch1 keeps running
        reprogram(0, 5, 2);
        clr_hist();
        bus.en[0] = 1'b1;
        cycles(10);
        check_eq("odd_clk", hist_clk[0] & 32'h3FF, 32'b1100011000);
        check_eq("ch1_undisturbed", hist_clk[1] & 32'h1FF, 32'b100100100);

        // Mid-period reload: current period finishes, then new shape
        reprogram(0, 4, 2);
        clr_hist();
        bus.en[0] = 1'b1;
        cycles(2);
        load_ch(0, 6, 3);
        cycles(14);
        check_eq("midload_clk", hist_clk[0] & 32'hFFFF, 32'b1100111000111000);
        check_eq("midload_ack", hist_ack[0] & 32'hFFFF, 32'h0800);

        // Boundaries: P=1 clamps to 2, H=0 stuck low, H>=P stuck high
        reprogram(0, 1, 1);
        clr_hist();
        bus.en[0] = 1'b1;
        cycles(6);
        check_eq("p1_clk", hist_clk[0] & 32'h3F, 32'b101010);
        reprogram(0, 3, 0);
        clr_hist();
        bus.en[0] = 1'b1;
        cycles(6);
        check_eq("h0_clk", hist_clk[0] & 32'h3F, 32'h0);
        check_eq("h0_tick", hist_tick[0] & 32'h3F, 32'b100100);
        reprogram(0, 4, 7);
        clr_hist();
        bus.en[0] = 1'b1;
        cycles(8);
        check_eq("hbig_clk", hist_clk[0] & 32'hFF, 32'hFF);
        check_eq("hbig_tick", hist_tick[0] & 32'hFF, 32'b10001000);

        // Enable drop and re-raise
        cycles(1);
        bus.en[0] = 1'b0;
        cycle();
        check_eq("endrop_out", 32'({bus.clk_out[0], bus.tick[0]}), 32'h0);
        bus.en[0] = 1'b1;
        cycle();
        check_eq("enrise_out", 32'({bus.clk_out[0], bus.tick[0]}), 32'h3);

        // Asynchronous reset mid-period restores defaults
        cycles(1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst_clk", 32'(bus.clk_out), 32'h0);
        check_eq("async_rst_tick", 32'(bus.tick), 32'h0);
        bus.en = 2'b11;
        #1 rst_n = 1'b1;
        clr_hist();
        cycles(10);
        check_eq("dflt_clk0", hist_clk[0] & 32'h3FF, 32'b1111100000);
        check_eq("dflt_clk1", hist_clk[1] & 32'h3FF, 32'b1111100000);
        check_eq("dflt_tick0", hist_tick[0] & 32'h3FF, 32'b1000000000);

`ifdef CLK_DIV_PHASE_ALIGN_EN
        // Different phases, then sync aligns both channels
        reprogram(0, 4, 2);
        reprogram(1, 6, 3);
        bus.en[0] = 1'b1;
        cycles(2);
        bus.en[1] = 1'b1;
        cycles(3);
        clr_hist();
        sync_v = 1'b1;
        $display("sync t=%0t", $time);
        cycle();
        sync_v = 1'b0;
        cycles(23);
        check_eq("sync_tick0", hist_tick[0] & 32'hFFFFFF, 32'h888888);
        check_eq("sync_tick1", hist_tick[1] & 32'hFFFFFF, 32'h820820);
        check_eq("sync_both", hist_tick[0] & hist_tick[1] & 32'hFFFFFF, 32'h800800);
`endif

        // Random traffic against the model
        bus.en = 2'b11;
        for (int k = 0; k < 400; k++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if ($urandom_range(15, 0) == 0) bus.en[ch] = ~bus.en[ch];
                if ($urandom_range(7, 0) == 0)
                    load_ch(ch, int'($urandom_range(8, 0)), int'($urandom_range(9, 0)));
            end
`ifdef CLK_DIV_PHASE_ALIGN_EN
            sync_v = ($urandom_range(19, 0) == 0);
`endif
            cycle();
        end
        sync_v = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
